mmio_bus_arbiter: RTL and testbench
===================================

// Module: mmio_bus_arbiter
// PURPOSE
// - Shares the single MMIO peripheral slave port (UART, LEDs, mode, buttons, timer at 0x8000_00xx) between two masters.
//   - Master 0: CPU memory controller.
//   - Master 1: debug/loader master.
// - Round-robin arbitration; one transaction in flight at a time.
// - Every transaction terminates, even when the slave withholds ready (e.g. UART TX busy): a timeout completes it with an error.
// - Sits between the masters and mmio_peripherals.
// PARAMETERS
// - TIMEOUT_CYCLES  1024          BUSY cycles before forced completion; 0 disables the timeout.
// - TIMEOUT_RDATA   32'hDEAD_BEEF rdata returned on a timed-out transaction.
// - CNT_W           10            timeout counter width; requires 2**CNT_W >= TIMEOUT_CYCLES.
// PORTS
// - clk           in   1   clock
// - resetn        in   1   synchronous, active-low reset
// - m0_valid      in   1   master 0 request; held until m0_ready
// - m0_write      in   1   1=write, 0=read
// - m0_addr       in   32  byte address
// - m0_wdata      in   32  write data
// - m0_wstrb      in   4   byte strobes
// - m0_rdata      out  32  read data; valid while m0_ready=1
// - m0_ready      out  1   one-cycle completion pulse
// - m1_*          --   --  same set as m0_*, for master 1
// - s_valid       out  1   request to peripherals
// - s_write       out  1   latched write flag
// - s_addr        out  32  latched address
// - s_wdata       out  32  latched write data
// - s_wstrb       out  4   latched byte strobes
// - s_rdata       in   32  peripheral read data
// - s_ready       in   1   peripheral one-cycle ack
// - err_clr       in   1   clears timeout_err and timeout_cnt
// - timeout_err   out  1   sticky: a timeout occurred since the last clear
// - timeout_cnt   out  8   saturating count of timeouts
// - grant_id      out  1   master currently or last granted
// BEHAVIOUR
// - Reset: state=IDLE, last_grant=1 (so m0 wins the first tie).
//   - All outputs 0: s_*, m*_ready, m*_rdata, timeout_err, timeout_cnt, grant_id.
//   - Reset mid-transaction aborts it: s_valid=0 after that edge; no ready pulse is issued.
// - FSM IDLE -> BUSY -> GAP -> IDLE.
// - IDLE, on any eligible m*_valid:
//   - Pick a master: if both request, grant the one != last_grant; otherwise grant the requester.
//   - Latch that master's write/addr/wdata/wstrb into the s_* registers and set grant_id.
//   - Go to BUSY with s_valid=1 on the next cycle.
// - BUSY:
//   - s_valid and the s_* fields are held constant; counter increments each cycle.
//   - s_ready=1 -> capture s_rdata into granted m*_rdata, pulse granted m*_ready for 1 cycle, last_grant<=grant_id, go to GAP.
//   - Counter reaches TIMEOUT_CYCLES-1 with s_ready=0 (and TIMEOUT_CYCLES!=0):
//     - m*_rdata<=TIMEOUT_RDATA; pulse m*_ready.
//     - timeout_err<=1; timeout_cnt+=1, saturating at 255.
//     - last_grant<=grant_id; go to GAP.
//   - The ungranted master is never driven ready; its m*_rdata holds its last value.
// - GAP (1 cycle):
//   - s_valid=0 so the slave's ready flop clears; the just-served master drops valid.
//   - The served master's m*_valid is ignored in GAP; the other master's request is not sampled until IDLE.
// - Latency, no contention: m_valid at cycle N -> s_valid at N+1; s_ready earliest at N+2; m_ready at N+3.
//   - Back-to-back issue rate: 1 transaction per 4 cycles minimum.
// - Master dropping valid during BUSY: no abort; the transaction completes and ready still pulses.
// - err_clr:
//   - Takes effect the next cycle.
//   - If it coincides with a timeout event, the event wins: err=1, cnt=1.
// - s_ready outside BUSY is ignored.
// - A master must not change its request fields while valid=1.
// STRUCTURE
// - mmio_arb_defs.vh holds: state encodings (IDLE=2'd0, BUSY=2'd1, GAP=2'd2), the default TIMEOUT_RDATA, and M0/M1 ids.
// - Sub-module mmio_rr_arb2 (combinational 2-way round-robin pick from req[1:0] and last_grant).
// - Counter, FSM and datapath latches live in the top.
// TESTING
// - Single read: m0 reads 0x8000_0010 with LED=2'b10 -> s_valid at N+1, m0_ready at N+3, m0_rdata=0x2, m1_ready never set.
// - Contention: m0 and m1 valid from cycle 0 -> grant order m0,m1,m0,m1 across 4 transactions; each master's addr reaches s_addr unmodified.
// - Timeout: TIMEOUT_CYCLES=8, slave never readies -> m1_ready on the 8th BUSY cycle, m1_rdata=0xDEADBEEF, timeout_err=1, timeout_cnt=1.
// - Stalled write: UART TX busy 20 cycles, then ready -> exactly one m0_ready pulse, s_wdata stable throughout, no timeout.
// - Reset in BUSY: resetn low 1 cycle -> s_valid=0 and m*_ready=0 next cycle; next m1 request is granted normally.
// - err_clr: 256 timeouts -> cnt=255 (saturates); pulse err_clr -> err=0, cnt=0.

Source files
------------

// File: rtl/mmio_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mmio_bus_arbiter_pkg: shared types and constants for the MMIO bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mmio_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } arb_state_t;

   localparam logic [31:0] c_timeout_rdata_def = 32'hDEAD_BEEF;
   localparam logic        c_m0_id             = 1'b0;
   localparam logic        c_m1_id             = 1'b1;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mmio_req_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_rr_arb2.sv
// ----------------------------------------------------------------------------
// mmio_rr_arb2: combinational 2-way round-robin pick
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmio_rr_arb2
   import mmio_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   always_comb begin
      grant_valid = |req;
      if (&req)
         grant_id = ~last_grant;
      else
         grant_id = req[1] ? c_m1_id : c_m0_id;
   end

endmodule

`default_nettype wire

// File: rtl/mmio_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mmio_bus_arbiter: round-robin sharing of the MMIO slave port by two masters,
// with a timeout that force-completes stalled transactions. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmio_bus_arbiter
   import mmio_bus_arbiter_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_RDATA  = c_timeout_rdata_def,
   parameter int          CNT_W          = 10
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic        m0_write,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic        m1_write,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic        s_write,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   input  logic        err_clr,
   output logic        timeout_err,
   output logic [7:0]  timeout_cnt,
   output logic        grant_id
);

   localparam logic [CNT_W-1:0] c_to_last = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

   arb_state_t       r_state;
   logic             r_last_grant;
   logic [CNT_W-1:0] r_cnt;
   logic             w_grant_valid;
   logic             w_pick;
   logic             w_timeout;
   logic [31:0]      w_done_rdata;
   mmio_req_t        w_req;

   // Requests are only looked at in IDLE; GAP deliberately masks them.
   mmio_rr_arb2 u_rr (
      .req         ({m1_valid, m0_valid} & {2{r_state == ST_IDLE}}),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant_id    (w_pick)
   );

   always_comb begin
      w_req        = (w_pick == c_m1_id) ? {m1_write, m1_addr, m1_wdata, m1_wstrb}
                                         : {m0_write, m0_addr, m0_wdata, m0_wstrb};
      w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == c_to_last);
      w_done_rdata = s_ready ? s_rdata : TIMEOUT_RDATA;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_last_grant <= c_m1_id;
         r_cnt        <= '0;
         grant_id     <= c_m0_id;
         s_valid      <= 1'b0;
         s_write      <= 1'b0;
         s_addr       <= '0;
         s_wdata      <= '0;
         s_wstrb      <= '0;
         m0_ready     <= 1'b0;
         m1_ready     <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
         timeout_err  <= 1'b0;
         timeout_cnt  <= '0;
      end else begin
         m0_ready <= 1'b0;
         m1_ready <= 1'b0;
         if (err_clr) begin
            timeout_err <= 1'b0;
            timeout_cnt <= '0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  grant_id                             <= w_pick;
                  {s_write, s_addr, s_wdata, s_wstrb} <= w_req;
                  s_valid                              <= 1'b1;
                  r_cnt                                <= '0;
                  r_state                              <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_cnt <= r_cnt + c_one;
               if (s_ready || w_timeout) begin
                  if (grant_id == c_m1_id) begin
                     m1_ready <= 1'b1;
                     m1_rdata <= w_done_rdata;
                  end else begin
                     m0_ready <= 1'b1;
                     m0_rdata <= w_done_rdata;
                  end
                  // A timeout landing with err_clr wins over the clear.
                  if (!s_ready) begin
                     timeout_err <= 1'b1;
                     timeout_cnt <= err_clr ? 8'd1 : sat_inc8(timeout_cnt);
                  end
                  s_valid      <= 1'b0;
                  r_last_grant <= grant_id;
                  r_state      <= ST_GAP;
               end
            end
            ST_GAP:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mmio_bus_arbiter: directed self-checking bench; one instance with a
// stallable slave model, one (TIMEOUT_CYCLES=8) with a slave that never readies.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mmio_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn, err_clr;
   logic        m0_valid, m0_write, m1_valid, m1_write;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;

   logic [31:0] m0_rdata_a, m1_rdata_a, s_addr_a, s_wdata_a, s_rdata_a;
   logic        m0_ready_a, m1_ready_a, s_valid_a, s_write_a, s_ready_a, terr_a, gid_a;
   logic [3:0]  s_wstrb_a;
   logic [7:0]  tcnt_a;

   logic [31:0] m0_rdata_t, m1_rdata_t, s_addr_t, s_wdata_t, s_rdata_t;
   logic        m0_ready_t, m1_ready_t, s_valid_t, s_write_t, s_ready_t, terr_t, gid_t;
   logic [3:0]  s_wstrb_t;
   logic [7:0]  tcnt_t;

   mmio_bus_arbiter dut_a (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata_a), .m0_ready(m0_ready_a),
      .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata_a), .m1_ready(m1_ready_a),
      .s_valid(s_valid_a), .s_write(s_write_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a),
      .s_wstrb(s_wstrb_a), .s_rdata(s_rdata_a), .s_ready(s_ready_a),
      .err_clr(err_clr), .timeout_err(terr_a), .timeout_cnt(tcnt_a), .grant_id(gid_a)
   );

   mmio_bus_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF), .CNT_W(3)) dut_t (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata_t), .m0_ready(m0_ready_t),
      .m1_valid(m1_valid), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata_t), .m1_ready(m1_ready_t),
      .s_valid(s_valid_t), .s_write(s_write_t), .s_addr(s_addr_t), .s_wdata(s_wdata_t),
      .s_wstrb(s_wstrb_t), .s_rdata(s_rdata_t), .s_ready(s_ready_t),
      .err_clr(err_clr), .timeout_err(terr_t), .timeout_cnt(tcnt_t), .grant_id(gid_t)
   );

   // Peripheral model: LED register at 0x10 reads 2'b10, other addresses a fixed pattern.
   function automatic logic [31:0] slave_read(input logic [31:0] a);
      return (a == 32'h8000_0010) ? 32'h0000_0002 : (a ^ 32'h1234_0000);
   endfunction

   int stall_cycles = 0;
   int wait_cnt;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s_ready_a <= 1'b0;
         s_rdata_a <= '0;
         wait_cnt  <= 0;
      end else begin
         s_ready_a <= 1'b0;
         if (s_valid_a && !s_ready_a) begin
            if (wait_cnt >= stall_cycles) begin
               s_ready_a <= 1'b1;
               s_rdata_a <= slave_read(s_addr_a);
               wait_cnt  <= 0;
            end else begin
               wait_cnt <= wait_cnt + 1;
            end
         end
      end
   end

   int          n_m0a = 0, n_m1a = 0, n_m0t = 0, n_m1t = 0, n_unstable = 0;
   logic        prev_sv = 1'b0;
   logic [31:0] prev_wd = '0;
   always @(negedge clk) begin
      if (m0_ready_a) n_m0a++;
      if (m1_ready_a) n_m1a++;
      if (m0_ready_t) n_m0t++;
      if (m1_ready_t) n_m1t++;
      if (prev_sv && s_valid_a && (s_wdata_a !== prev_wd)) n_unstable++;
      prev_sv = s_valid_a;
      prev_wd = s_wdata_a;
   end

   int checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      m0_valid = 1'b0;
      m1_valid = 1'b0;
      resetn   = 1'b0;
      tick(2);
      resetn   = 1'b1;
      tick();
   endtask

   task automatic wait_ready_a(input int who, input int budget, input string tag);
      int k = 0;
      while ((((who == 0) ? m0_ready_a : m1_ready_a) !== 1'b1) && (k < budget)) begin
         tick();
         k++;
      end
      check(tag, {31'd0, (who == 0) ? m0_ready_a : m1_ready_a}, 32'd1);
   endtask

   task automatic wait_svalid_a(input int budget);
      int k = 0;
      while ((s_valid_a !== 1'b1) && (k < budget)) begin
         tick();
         k++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int base0, base1, baseu;

   initial begin
      resetn = 1'b0; err_clr = 1'b0; s_rdata_t = '0; s_ready_t = 1'b0;
      m0_valid = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      tick(3);

      // Reset state
      check("rst_s_valid", {31'd0, s_valid_a}, 32'd0);
      check("rst_grant_id", {31'd0, gid_a}, 32'd0);
      check("rst_m0_rdata", m0_rdata_a, 32'd0);
      check("rst_timeout", {23'd0, terr_a, tcnt_a}, 32'd0);
      resetn = 1'b1;
      tick();

      // Single read with exact latency
      stall_cycles = 0;
      base1 = n_m1a;
      m0_write = 1'b0; m0_addr = 32'h8000_0010; m0_valid = 1'b1;
      tick();
      check("rd_s_valid_n1", {31'd0, s_valid_a}, 32'd1);
      check("rd_s_addr", s_addr_a, 32'h8000_0010);
      tick();
      check("rd_m0_ready_n2", {31'd0, m0_ready_a}, 32'd0);
      tick();
      check("rd_m0_ready_n3", {31'd0, m0_ready_a}, 32'd1);
      check("rd_m0_rdata", m0_rdata_a, 32'h0000_0002);
      m0_valid = 1'b0;
      tick(2);
      check("rd_m1_never_ready", n_m1a - base1, 32'd0);

      // Contention: both held valid, expect strict alternation from m0
      do_reset();
      m0_addr = 32'h8000_0004; m1_addr = 32'h8000_0008;
      m0_valid = 1'b1; m1_valid = 1'b1;
      for (int t = 0; t < 4; t++) begin
         wait_svalid_a(8);
         check($sformatf("cont_grant_%0d", t), {31'd0, gid_a}, t % 2);
         check($sformatf("cont_s_addr_%0d", t), s_addr_a, (t % 2) ? 32'h8000_0008 : 32'h8000_0004);
         wait_ready_a(t % 2, 8, $sformatf("cont_ready_%0d", t));
         check($sformatf("cont_rdata_%0d", t), (t % 2) ? m1_rdata_a : m0_rdata_a,
               (t % 2) ? 32'h9234_0008 : 32'h9234_0004);
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
      tick(3);

      // Stalled write: slave holds off 20 cycles
      stall_cycles = 20;
      base0 = n_m0a; baseu = n_unstable;
      m0_write = 1'b1; m0_addr = 32'h8000_0000; m0_wdata = 32'h0000_0041; m0_wstrb = 4'b0001;
      m0_valid = 1'b1;
      tick();
      check("wr_s_fields", {s_write_a, s_wstrb_a, s_wdata_a[26:0]}, {1'b1, 4'b0001, 27'h41});
      wait_ready_a(0, 40, "wr_ready");
      m0_valid = 1'b0;
      tick(3);
      check("wr_one_pulse", n_m0a - base0, 32'd1);
      check("wr_wdata_stable", n_unstable - baseu, 32'd0);
      check("wr_no_timeout", {31'd0, terr_a}, 32'd0);

      // Reset while BUSY aborts the transaction
      base0 = n_m0a;
      m0_write = 1'b0; m0_addr = 32'h8000_0010; m0_valid = 1'b1;
      tick(3);
      resetn = 1'b0; m0_valid = 1'b0;
      tick();
      check("rstbusy_s_valid", {31'd0, s_valid_a}, 32'd0);
      check("rstbusy_m0_ready", {31'd0, m0_ready_a}, 32'd0);
      resetn = 1'b1; stall_cycles = 0;
      tick();
      m1_write = 1'b0; m1_addr = 32'h8000_000C; m1_valid = 1'b1;
      tick();
      check("rstbusy_m1_grant", {s_valid_a, gid_a}, 2'b11);
      wait_ready_a(1, 8, "rstbusy_m1_ready");
      check("rstbusy_m1_rdata", m1_rdata_a, 32'h9234_000C);
      m1_valid = 1'b0;
      tick(2);
      check("rstbusy_no_m0_ready", n_m0a - base0, 32'd0);

      // Timeout on the 8-cycle instance
      do_reset();
      base0 = n_m0t;
      m1_addr = 32'h8000_0014; m1_valid = 1'b1;
      tick(8);
      check("tmo_not_yet", {31'd0, m1_ready_t}, 32'd0);
      tick();
      check("tmo_m1_ready", {31'd0, m1_ready_t}, 32'd1);
      check("tmo_m1_rdata", m1_rdata_t, 32'hDEAD_BEEF);
      check("tmo_err_cnt", {terr_t, tcnt_t}, {1'b1, 8'd1});

      // Keep m1 requesting so timeouts repeat until the counter saturates
      base1 = n_m1t;
      for (int k = 0; k < 4000 && (n_m1t - base1) < 260; k++) tick();
      check("tmo_many_pulses", {31'd0, (n_m1t - base1) >= 260}, 32'd1);
      m1_valid = 1'b0;
      tick(12);
      check("tmo_saturated", {terr_t, tcnt_t}, {1'b1, 8'd255});
      check("tmo_m0_never_ready", n_m0t - base0, 32'd0);

      // err_clr coinciding with a timeout: the event wins
      m1_valid = 1'b1;
      tick(8);
      err_clr = 1'b1;
      tick();
      check("clr_coincide_ready", {31'd0, m1_ready_t}, 32'd1);
      check("clr_coincide", {terr_t, tcnt_t}, {1'b1, 8'd1});
      err_clr = 1'b0; m1_valid = 1'b0;
      tick();

      // Plain err_clr
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("clr_plain", {terr_t, tcnt_t}, {1'b0, 8'd0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
